regfile_sb: RTL

- Parametrised general-purpose register file with two write-back ports, two bypassed read ports and an integrated per-register busy scoreboard.
- Sits between decode/issue and write-back in the pipelined core.
- Decode reads operands and hazard status in the same cycle.
- A registered debug read port exposes architectural state to the debug unit.

---
 rtl/regfile_sb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with two write-back ports,
// two combinational (optionally bypassed) read ports, a per-register busy
// scoreboard for hazard detection and a registered debug read port.
module regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_addr,
    input  logic [XLEN-1:0] w0_data,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    input  logic [XLEN-1:0] w1_data,
    input  logic [AW-1:0]   r0_addr,
    output logic [XLEN-1:0] r0_data,
    output logic            r0_busy,
    input  logic [AW-1:0]   r1_addr,
    output logic [XLEN-1:0] r1_data,
    output logic            r1_busy,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            sb_flush,
    input  logic            dbg_req,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic            dbg_valid
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            w0_legal;
    logic            w1_legal;
    logic            iss_legal;

    // Qualify write/issue requests: r0 is untouchable when hardwired, and an
    // active reset suppresses in-flight writes so nothing is forwarded either.
    always_comb begin
        w0_legal  = w0_en  && !reset && !(ZERO_R0 && (w0_addr  == '0));
        w1_legal  = w1_en  && !reset && !(ZERO_R0 && (w1_addr  == '0));
        iss_legal = iss_en && !(ZERO_R0 && (iss_addr == '0));
    end

    // Register array; w1 is applied after w0 so it wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (w0_legal) begin
                regs[w0_addr] <= w0_data;
            end
            if (w1_legal) begin
                regs[w1_addr] <= w1_data;
            end
        end
    end

    // Scoreboard next state: retire clears, issue sets (beats a retire of the
    // same register), flush clears everything including this cycle's issue.
    always_comb begin
        busy_next = busy;
        if (w0_legal) begin
            busy_next[w0_addr] = 1'b0;
        end
        if (w1_legal) begin
            busy_next[w1_addr] = 1'b0;
        end
        if (iss_legal) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (sb_flush) begin
            busy_next = '0;
        end
        if (ZERO_R0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read port 0: hardwired zero, then w1 / w0 forwarding, then array.
    always_comb begin
        r0_data = regs[r0_addr];
        r0_busy = busy[r0_addr];
        if (BYPASS) begin
            if (w1_legal && (w1_addr == r0_addr)) begin
                r0_data = w1_data;
                r0_busy = 1'b0;
            end else if (w0_legal && (w0_addr == r0_addr)) begin
                r0_data = w0_data;
                r0_busy = 1'b0;
            end
        end
        if (ZERO_R0 && (r0_addr == '0)) begin
            r0_data = '0;
            r0_busy = 1'b0;
        end
    end

    // Read port 1: same structure as read port 0.
    always_comb begin
        r1_data = regs[r1_addr];
        r1_busy = busy[r1_addr];
        if (BYPASS) begin
            if (w1_legal && (w1_addr == r1_addr)) begin
                r1_data = w1_data;
                r1_busy = 1'b0;
            end else if (w0_legal && (w0_addr == r1_addr)) begin
                r1_data = w0_data;
                r1_busy = 1'b0;
            end
        end
        if (ZERO_R0 && (r1_addr == '0)) begin
            r1_data = '0;
            r1_busy = 1'b0;
        end
    end

    // Debug port: samples the pre-write array value, valid pulses one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_data  <= '0;
            dbg_valid <= 1'b0;
        end else begin
            dbg_valid <= dbg_req;
            if (dbg_req) begin
                dbg_data <= regs[dbg_addr];
            end
        end
    end

endmodule
